// File: rtl/muldiv_unit.sv
// muldiv_unit: multicycle signed 32x32 multiply (Booth radix-2) and divide (restoring) coprocessor.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        op_q, op_d, an_q, an_d, bn_q, bn_d, qm1_q, qm1_d;
  logic        done_q, done_d, dz_q, dz_d;
  logic [32:0] acc_q, acc_d, m_q, m_d;
  logic [31:0] q_q, q_d, hi_q, hi_d, lo_q, lo_d;
  logic [32:0] booth, trial;
  logic [31:0] a_mag, b_mag, quot, rem;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      an_q    <= 1'b0;
      bn_q    <= 1'b0;
      qm1_q   <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      acc_q   <= '0;
      m_q     <= '0;
      q_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      an_q    <= an_d;
      bn_q    <= bn_d;
      qm1_q   <= qm1_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      q_q     <= q_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  // A holds the Booth accumulator for MULT and the partial remainder for DIV; Q is multiplier or dividend/quotient.
  always_comb begin
    a_mag   = a[31] ? -a : a;
    b_mag   = b[31] ? -b : b;
    booth   = (q_q[0] & ~qm1_q) ? acc_q - m_q : (~q_q[0] & qm1_q) ? acc_q + m_q : acc_q;
    trial   = {acc_q[31:0], q_q[31]} - m_q;
    quot    = (an_q ^ bn_q) ? -q_q : q_q;
    rem     = an_q ? -acc_q[31:0] : acc_q[31:0];
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    an_d    = an_q;
    bn_d    = bn_q;
    qm1_d   = qm1_q;
    acc_d   = acc_q;
    m_d     = m_q;
    q_d     = q_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        op_d = op;
        an_d = a[31];
        bn_d = b[31];
        if (op && b == 32'd0) begin
          done_d = 1'b1;
          dz_d   = 1'b1;
        end else begin
          state_d = RUN;
          cnt_d   = '0;
          acc_d   = '0;
          qm1_d   = 1'b0;
          q_d     = op ? a_mag : b;
          m_d     = op ? {1'b0, b_mag} : {a[31], a};
        end
      end
      RUN: begin
        if (op_q) begin
          acc_d = trial[32] ? {acc_q[31:0], q_q[31]} : trial;
          q_d   = {q_q[30:0], ~trial[32]};
        end else begin
          acc_d = {booth[32], booth[32:1]};
          q_d   = {booth[0], q_q[31:1]};
          qm1_d = q_q[0];
        end
        cnt_d   = cnt_q + 6'd1;
        state_d = (cnt_q == 6'd31) ? FIX : RUN;
      end
      FIX: begin
        hi_d    = op_q ? rem : acc_q[31:0];
        lo_d    = op_q ? quot : q_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = state_q != IDLE;
  assign done     = done_q;
  assign div_zero = dz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against a 64-bit arithmetic reference.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset, start, op;
  logic [31:0] a, b, hi, lo;
  logic        busy, done, div_zero;
  int          total = 0, bad = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;
  logic [31:0] specials [5] = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(logic o, logic [31:0] x, logic [31:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    if (!o) return 64'(sx * sy);
    return {32'(sx % sy), 32'(sx / sy)};
  endfunction

  task automatic issue(logic o, logic [31:0] x, logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    op    = 1'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_done(string tag, logic o, logic [31:0] x, logic [31:0] y, int exp_lat);
    int lat = 0;
    int nb = 0;
    logic [63:0] r;
    logic dz = o && (y == 32'd0);
    while (!done && lat < 40) begin
      if (busy) nb++;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, "_dz"}, 64'(div_zero), 64'(dz));
    if (dz) begin
      chk({tag, "_lat"}, 64'(lat), 64'd0);
    end else begin
      r = model(o, x, y);
      exp_hi = r[63:32];
      exp_lo = r[31:0];
      chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_busy_cycles"}, 64'(nb), 64'(exp_lat));
    end
    chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
  endtask

  task automatic do_op(string tag, logic o, logic [31:0] x, logic [31:0] y);
    issue(o, x, y);
    wait_done(tag, o, x, y, 33);
    @(negedge clk);
    chk({tag, "_pulse"}, 64'({done, div_zero}), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    return ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
  endfunction

  initial begin
    int seen;
    logic o;
    logic [31:0] x, y;
    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", {hi, lo}, 64'd0);
    chk("rst_flags", 64'({busy, done, div_zero}), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    do_op("mul_7_m3", 1'b0, 32'd7, -32'sd3);
    chk("mul_7_m3_lit", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    do_op("mul_min_min", 1'b0, 32'h80000000, 32'h80000000);
    chk("mul_min_min_lit", {hi, lo}, 64'h40000000_00000000);
    do_op("mul_min_1", 1'b0, 32'h80000000, 32'd1);
    chk("mul_min_1_lit", {hi, lo}, 64'hFFFFFFFF_80000000);
    do_op("div_m7_2", 1'b1, -32'sd7, 32'd2);
    chk("div_m7_2_lit", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    do_op("div_7_m2", 1'b1, 32'd7, -32'sd2);
    chk("div_7_m2_lit", {hi, lo}, 64'h00000001_FFFFFFFD);
    do_op("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF);
    chk("div_ovf_lit", {hi, lo}, 64'h00000000_80000000);
    do_op("div_zero", 1'b1, 32'd5, 32'd0);
    chk("div_zero_hold", {hi, lo}, 64'h00000000_80000000);

    issue(1'b0, 32'h1234, 32'h5678);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 1'b1; a = 32'd99; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore", 1'b0, 32'h1234, 32'h5678, 27);
    @(negedge clk);

    issue(1'b0, 32'd5, 32'd6);
    wait_done("b2b1", 1'b0, 32'd5, 32'd6, 33);
    issue(1'b1, 32'd100, 32'd7);
    chk("b2b_drop", 64'(done), 64'd0);
    wait_done("b2b2", 1'b1, 32'd100, 32'd7, 33);
    @(negedge clk);

    issue(1'b0, 32'hDEADBEEF, 32'h12345678);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_out", {hi, lo}, 64'd0);
    chk("midrst_flags", 64'({busy, done, div_zero}), 64'd0);
    reset = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("midrst_no_done", 64'(seen), 64'd0);
    do_op("after_rst", 1'b0, 32'd3, 32'd4);
    chk("after_rst_lit", {hi, lo}, 64'd12);

    for (int i = 0; i < 40; i++) begin
      o = 1'($urandom);
      x = pick();
      y = (o && $urandom_range(0, 7) == 0) ? 32'd0 : pick();
      do_op($sformatf("rnd%0d", i), o, x, y);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
